// File: rtl/register_scanner.sv
// register_scanner: debug read-out engine that walks a register file through
// one read port and streams (address, value) pairs over a valid/ready link.
// Registers that read as zero can optionally be suppressed.
module register_scanner #(
  parameter int ADDR_W    = 5,
  parameter int DATA_W    = 32,
  parameter int FIRST_REG = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              skip_zero,
  output logic [ADDR_W-1:0] rf_addr,
  input  logic [DATA_W-1:0] rf_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_data,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   count
);

  localparam logic [ADDR_W-1:0] FIRST_IDX = ADDR_W'(FIRST_REG);

  typedef enum logic [1:0] {IDLE, READ, HOLD, DONE} state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] idx;
  logic              skz;
  logic              last_idx;
  logic              drop_reg;

  // The last-address test happens before any increment, so idx never wraps
  // back to x0 inside one scan.
  assign last_idx = (idx == {ADDR_W{1'b1}});
  assign drop_reg = skz && (rf_data == '0);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state decode plus the purely state-derived outputs.
  always_comb begin
    state_nxt = state;
    busy      = 1'b1;
    done      = 1'b0;
    rf_addr   = idx;
    case (state)
      IDLE: begin
        busy    = 1'b0;
        rf_addr = '0;
        if (start) state_nxt = READ;
      end
      READ: begin
        if (drop_reg) begin
          if (last_idx) state_nxt = DONE;
        end else begin
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) state_nxt = last_idx ? DONE : READ;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Scan index, skip latch, output pair snapshot and accepted-pair counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx       <= '0;
      skz       <= 1'b0;
      out_valid <= 1'b0;
      out_addr  <= '0;
      out_data  <= '0;
      count     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            idx   <= FIRST_IDX;
            skz   <= skip_zero;
            count <= '0;
          end
        end
        READ: begin
          if (drop_reg) begin
            if (!last_idx) idx <= idx + 1'b1;
          end else begin
            // Snapshot the value now; later writes to this register must not
            // disturb the pair that is waiting for the consumer.
            out_addr  <= idx;
            out_data  <= rf_data;
            out_valid <= 1'b1;
          end
        end
        HOLD: begin
          if (out_ready) begin
            count     <= count + 1'b1;
            out_valid <= 1'b0;
            if (!last_idx) idx <= idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/register_scanner.md
Name: register_scanner

Overview:
Debug read-out engine that walks the register file through one of its read ports. It streams every architectural register as an (address, value) pair over a valid/ready interface, for dump logic or a testbench monitor. It sits beside register_file and owns one read port (drives the address, samples the combinational data) while the scan is active. An optional mode suppresses zero-valued registers.

Parameters:
ADDR_W, 5, register address width (matches RegAddress)
DATA_W, 32, register data width (matches Word)
FIRST_REG, 1, first address scanned; x0 is hardwired zero and is skipped by default

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  asynchronous, active-high; clears all state immediately
start  input  1  begin a scan; honoured only in IDLE
skip_zero  input  1  sampled with start; 1 = do not emit registers whose value is 0
rf_addr  output  ADDR_W  address to the register file read port
rf_data  input  DATA_W  combinational read data for rf_addr
out_valid  output  1  out_addr/out_data hold a pair
out_ready  input  1  consumer accepts the pair when out_valid && out_ready at a rising edge
out_addr  output  ADDR_W  register address of the emitted pair
out_data  output  DATA_W  register value snapshot
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse after the last register is handled
count  output  ADDR_W+1  number of pairs accepted in the current or most recent scan

Behaviour:
- States: IDLE, READ, HOLD, DONE. Internal idx (ADDR_W bits), skip_zero latch skz.
- Reset (async) forces: state=IDLE, idx=0, skz=0, out_valid=0, out_addr=0, out_data=0, done=0, count=0. rf_addr=0 in IDLE.
- IDLE: busy=0. On start=1: idx<=FIRST_REG, skz<=skip_zero, count<=0, go to READ. start is ignored in all other states.
- READ: rf_addr=idx. At the edge:
  - if skz && rf_data==0, the register is skipped. Then if idx==2^ADDR_W-1 go to DONE; else idx<=idx+1 and stay in READ.
  - otherwise out_addr<=idx, out_data<=rf_data, out_valid<=1, go to HOLD.
- HOLD: out_valid=1. out_addr/out_data stay stable until accepted. rf_addr=idx; later writes to that register do not change out_data (snapshot semantics). On out_ready=1:
  - count<=count+1, out_valid<=0.
  - if idx==2^ADDR_W-1 go to DONE; else idx<=idx+1 and go to READ.
- DONE: done=1 for exactly this one cycle, busy=1. Next state is IDLE. count holds its final value until the next start or reset.
- Wrap-around: the last-address check is made before incrementing, so idx never wraps to 0 and x0 is never re-read within a scan.
- Latency: 1 cycle start→READ. Minimum 2 cycles per emitted register (READ + HOLD with out_ready=1). Skipped registers cost 1 cycle each.
- out_ready while out_valid=0 has no effect. out_valid never drops without a handshake except on reset.
- count width ADDR_W+1 holds a full scan of 2^ADDR_W registers when FIRST_REG=0.
- A reset mid-scan (any state, including HOLD with a pending pair) aborts immediately. No done pulse; the next start rescans from FIRST_REG.
- start asserted in the same cycle that DONE is exited is ignored. A scan begins only from IDLE.

Test Plan:
- Preload xi = 10*i+1 (x1..x31), skip_zero=0, out_ready=1 constant → 31 pairs (1,11)…(31,311) in order, each 2 cycles apart; done pulses once; count=31.
- Same preload, out_ready low for 5 cycles during the pair for x7 → out_valid stays high with out_addr=7 and out_data=71 stable for those cycles; the scan then resumes with x8.
- Only x3=5 and x20=0xFFFFFFFF nonzero, skip_zero=1 → exactly two pairs, (3,5) then (20,0xFFFFFFFF); count=2; done pulses 1 cycle after the x31 check.
- While holding the pair for x5=51, write x5←99 through the write port → out_data stays 51; a second scan reports (5,99).
- Assert reset while in HOLD at x12 → out_valid, busy, and count go to 0 without waiting for clk; no done pulse; a new start restarts at x1.
- Pulse start repeatedly while busy → no restart, pair sequence uninterrupted; an all-zero file with skip_zero=1 → no pairs, done after 31 READ cycles, count=0.
